// File: rtl/uart_tx_param.sv
// Parameterised UART transmitter: a small word FIFO feeds a frame FSM that
// serialises start, data (LSB first), optional parity and one or two stop bits.
module uart_tx_param #(
   parameter int DATA_WIDTH   = 8,
   parameter int CLKS_PER_BIT = 16,
   parameter int FIFO_DEPTH   = 4
) (
   input  logic                                 clk,
   input  logic                                 rst,
   input  logic [DATA_WIDTH-1:0]                P_data,
   input  logic                                 Data_valid,
   output logic                                 Data_ready,
   input  logic                                 Par_en,
   input  logic                                 Par_type,
   input  logic                                 Stop2,
   output logic                                 TX_out,
   output logic                                 Busy,
   output logic [$clog2(FIFO_DEPTH+1)-1:0]      Fifo_count
);

   localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
   localparam int PTR_W = $clog2(FIFO_DEPTH);
   localparam int BIT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
   localparam int IDX_W = $clog2(DATA_WIDTH);
   localparam int ENT_W = DATA_WIDTH + 3;

   localparam logic [BIT_W-1:0] BIT_RELOAD = BIT_W'(CLKS_PER_BIT - 1);
   localparam logic [IDX_W-1:0] IDX_LAST   = IDX_W'(DATA_WIDTH - 1);
   localparam logic [CNT_W-1:0] CNT_FULL   = CNT_W'(FIFO_DEPTH);

   typedef enum logic [2:0] {
      IDLE = 3'd0,
      STR  = 3'd1,
      DATA = 3'd2,
      PAR  = 3'd3,
      STP  = 3'd4
   } state_t;

   // Handshake: a word transfers on a rising edge where Data_valid and
   // Data_ready are both 1; Data_ready never depends on Data_valid.

   // ---------------- word FIFO ----------------
   logic [ENT_W-1:0] mem [FIFO_DEPTH];
   logic [PTR_W-1:0] wr_ptr;
   logic [PTR_W-1:0] rd_ptr;
   logic             ready_en;
   logic             push;
   logic             pop;
   logic [ENT_W-1:0] head;

   assign Data_ready = ready_en && (Fifo_count != CNT_FULL);
   assign push       = Data_valid && Data_ready;
   assign head       = mem[rd_ptr];

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr     <= '0;
         rd_ptr     <= '0;
         Fifo_count <= '0;
         ready_en   <= 1'b0;
      end else begin
         ready_en <= 1'b1;
         if (push) wr_ptr <= wr_ptr + 1'b1;
         if (pop)  rd_ptr <= rd_ptr + 1'b1;
         case ({push, pop})
            2'b10:   Fifo_count <= Fifo_count + 1'b1;
            2'b01:   Fifo_count <= Fifo_count - 1'b1;
            default: Fifo_count <= Fifo_count;
         endcase
      end
   end

   // Entry layout: {stop2, par_type, par_en, data}
   always_ff @(posedge clk) begin
      if (!rst && push) mem[wr_ptr] <= {Stop2, Par_type, Par_en, P_data};
   end

   // ---------------- frame FSM ----------------
   state_t                state;
   state_t                state_n;
   logic [BIT_W-1:0]      bit_cnt;
   logic [BIT_W-1:0]      bit_cnt_n;
   logic [IDX_W-1:0]      idx;
   logic [IDX_W-1:0]      idx_n;
   logic [DATA_WIDTH-1:0] cur_sh;
   logic [DATA_WIDTH-1:0] cur_sh_n;
   logic                  cur_pe;
   logic                  cur_pe_n;
   logic                  cur_par;
   logic                  cur_par_n;
   logic                  cur_s2;
   logic                  cur_s2_n;
   logic                  tick;
   logic                  tx_n;

   assign tick = (bit_cnt == '0);

   always_comb begin
      state_n   = state;
      idx_n     = idx;
      cur_sh_n  = cur_sh;
      cur_pe_n  = cur_pe;
      cur_par_n = cur_par;
      cur_s2_n  = cur_s2;
      pop       = 1'b0;

      unique case (state)
         IDLE: begin
            if (Fifo_count != '0) begin
               pop     = 1'b1;
               state_n = STR;
            end
         end
         STR: begin
            if (tick) begin
               state_n = DATA;
               idx_n   = '0;
            end
         end
         DATA: begin
            if (tick) begin
               if (idx == IDX_LAST) begin
                  state_n = cur_pe ? PAR : STP;
                  idx_n   = '0;
               end else begin
                  idx_n    = idx + 1'b1;
                  cur_sh_n = cur_sh >> 1;
               end
            end
         end
         PAR: begin
            if (tick) begin
               state_n = STP;
               idx_n   = '0;
            end
         end
         STP: begin
            if (tick) begin
               if (cur_s2 && (idx == '0)) begin
                  idx_n = IDX_W'(1);
               end else if (Fifo_count != '0) begin
                  pop     = 1'b1;
                  state_n = STR;
               end else begin
                  state_n = IDLE;
               end
            end
         end
         default: state_n = IDLE;
      endcase

      // Parity is fixed when the word is taken, so the shifter can consume data.
      if (pop) begin
         cur_sh_n  = head[DATA_WIDTH-1:0];
         cur_pe_n  = head[DATA_WIDTH];
         cur_par_n = (^head[DATA_WIDTH-1:0]) ^ head[DATA_WIDTH+1];
         cur_s2_n  = head[DATA_WIDTH+2];
      end

      if (state_n == IDLE)                 bit_cnt_n = '0;
      else if ((state == IDLE) || tick)    bit_cnt_n = BIT_RELOAD;
      else                                 bit_cnt_n = bit_cnt - 1'b1;

      unique case (state_n)
         IDLE:    tx_n = 1'b1;
         STR:     tx_n = 1'b0;
         DATA:    tx_n = cur_sh_n[0];
         PAR:     tx_n = cur_par_n;
         STP:     tx_n = 1'b1;
         default: tx_n = 1'b1;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state   <= IDLE;
         bit_cnt <= '0;
         idx     <= '0;
         cur_sh  <= '0;
         cur_pe  <= 1'b0;
         cur_par <= 1'b0;
         cur_s2  <= 1'b0;
         TX_out  <= 1'b1;
         Busy    <= 1'b0;
      end else begin
         state   <= state_n;
         bit_cnt <= bit_cnt_n;
         idx     <= idx_n;
         cur_sh  <= cur_sh_n;
         cur_pe  <= cur_pe_n;
         cur_par <= cur_par_n;
         cur_s2  <= cur_s2_n;
         TX_out  <= tx_n;
         Busy    <= (state_n != IDLE);
      end
   end

endmodule

// File: doc/uart_tx_param.md
UART_TX_PARAM -- requirements
Module: uart_tx_param

Interface
REQ-001 Parameters SHALL be, one per line (name, default, meaning):
- DATA_WIDTH, 8, data bits per frame; legal 5..9.
- CLKS_PER_BIT, 16, clk cycles per serial bit; legal >=1.
- FIFO_DEPTH, 4, input word buffer depth; power of 2, >=2.
REQ-002 Ports SHALL be, one per line (name direction width meaning):
- clk  in  1  single clock; all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- P_data  in  DATA_WIDTH  parallel word to send.
- Data_valid  in  1  word offered.
- Data_ready  out  1  buffer can accept a word.
- Par_en  in  1  parity bit enabled for this word.
- Par_type  in  1  0 = even, 1 = odd.
- Stop2  in  1  1 = two stop bits, 0 = one.
- TX_out  out  1  serial line; idle high.
- Busy  out  1  frame in progress.
- Fifo_count  out  $clog2(FIFO_DEPTH+1)  words buffered.

Function
REQ-003 The block SHALL accept a word on a rising edge where Data_valid and Data_ready are both 1, storing P_data, Par_en, Par_type and Stop2 together as one FIFO entry.
REQ-004 Data_ready SHALL be 0 when Fifo_count == FIFO_DEPTH, even if a pop occurs on the same edge.
REQ-005 A push and a pop on the same edge with the FIFO not full SHALL leave Fifo_count unchanged.
REQ-006 The FSM SHALL have the states IDLE, STR, DATA, PAR and STP.
REQ-007 In IDLE with Fifo_count > 0, the FSM SHALL pop the head entry and enter STR on the same edge.
REQ-008 A word accepted into an empty FIFO while IDLE SHALL start its frame one cycle after acceptance.
REQ-009 Each state SHALL hold each bit for exactly CLKS_PER_BIT cycles, timed by a bit counter that reloads at every bit boundary.
REQ-010 TX_out SHALL be:
- IDLE: 1.
- STR: 0.
- DATA: data bits LSB first, DATA_WIDTH bits.
- PAR: (^data) XOR Par_type.
- STP: 1.
REQ-011 Transitions SHALL be STR->DATA; DATA->PAR if Par_en, else DATA->STP; PAR->STP.
REQ-012 STP SHALL last one bit period, or two if the stored Stop2 = 1.
REQ-013 At the end of STP, the FSM SHALL pop and go directly to STR if Fifo_count > 0, with no idle bit; otherwise it SHALL go to IDLE.
REQ-014 Frame length SHALL be (1 + DATA_WIDTH + Par_en + 1 + Stop2) * CLKS_PER_BIT cycles.
REQ-015 Busy SHALL be 1 whenever the state is not IDLE.
REQ-016 TX_out and Busy SHALL be registered outputs with no combinational path from inputs.
REQ-017 Changes to the inputs during a frame SHALL NOT affect that frame; only stored values are used.

Reset
REQ-018 While rst = 1 at a rising edge, the block SHALL set state = IDLE, TX_out = 1, Busy = 0, Fifo_count = 0, Data_ready = 0, and clear the bit counter.
REQ-019 Data_valid SHALL be ignored while rst = 1.
REQ-020 Data_ready SHALL be 1 on the first edge after rst deasserts.
REQ-021 Reset asserted mid-frame SHALL abort the frame and flush the FIFO; TX_out = 1 and Busy = 0 after that edge, and no queued word is sent.

Verification
All scenarios use DATA_WIDTH = 8 and CLKS_PER_BIT = 4.
REQ-022 Reset: hold rst for 2 cycles, then release -> TX_out = 1, Busy = 0, Fifo_count = 0, and Data_ready = 1 one edge after release.
REQ-023 Even parity: push 0x9A with Par_en = 1, Par_type = 0, Stop2 = 0 -> TX_out sequence 0, 0,1,0,1,1,0,0,1, 0, 1 at 4 cycles per bit; Busy high for 44 cycles.
REQ-024 Odd parity, two stops: push 0x01 with Par_en = 1, Par_type = 1, Stop2 = 1 -> parity bit 0, two stop bits; Busy high for 48 cycles.
REQ-025 Back-to-back: push 5 words on consecutive edges with Par_en = 0 and Stop2 = 0 -> Fifo_count reaches 4 and Data_ready = 0; frames are contiguous; Busy high continuously for 200 cycles, then IDLE.
REQ-026 Reset mid-frame: assert rst during data bit 3 with 2 words queued -> next edge TX_out = 1, Busy = 0, Fifo_count = 0; the line stays idle afterwards.
